// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the frequency meter: FSM states, datapath
// widths and the reciprocal divider iteration count.
package freq_meter_pkg;

    localparam int CTRL_W    = 32;
    localparam int SAMPLE_W  = 8;
    localparam int DIV_ITERS = 33;

    typedef enum logic [1:0] {
        WAIT_FIRST = 2'd0,
        MEASURE    = 2'd1,
        DIVIDE     = 2'd2
    } state_e;

    // A 33-bit quotient only sets its top bit for d == 1; clamp that to all ones.
    function automatic logic [CTRL_W-1:0] sat_quot(input logic [CTRL_W:0] q);
        return q[CTRL_W] ? {CTRL_W{1'b1}} : q[CTRL_W-1:0];
    endfunction

endpackage

// File: rtl/freq_meter_recip_div.sv
// Sequential restoring divider computing floor(2^32 / d), one quotient bit
// per clock over DIV_ITERS iterations, with a one-cycle done pulse.
module freq_meter_recip_div
    import freq_meter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [CTRL_W-1:0] d_i,
    output logic              done_o,
    output logic [CTRL_W-1:0] q_o
);

    localparam int ITER_W = $clog2(DIV_ITERS);

    logic [CTRL_W-1:0] d_q, d_d;
    logic [CTRL_W-1:0] rem_q, rem_d;
    logic [CTRL_W:0]   quo_q, quo_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic              run_q, run_d;
    logic              done_q, done_d;

    logic              num_bit;
    logic [CTRL_W:0]   trial;

    always_comb begin
        d_d    = d_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        iter_d = iter_q;
        run_d  = run_q;
        done_d = 1'b0;

        // The dividend 2^32 has a single set bit, shifted in on the first iteration.
        num_bit = (iter_q == '0);
        trial   = {rem_q, num_bit};

        if (start_i) begin
            d_d    = d_i;
            rem_d  = '0;
            quo_d  = '0;
            iter_d = '0;
            run_d  = 1'b1;
        end else if (run_q) begin
            if (trial >= {1'b0, d_q}) begin
                rem_d = CTRL_W'(trial - {1'b0, d_q});
                quo_d = {quo_q[CTRL_W-1:0], 1'b1};
            end else begin
                rem_d = CTRL_W'(trial);
                quo_d = {quo_q[CTRL_W-1:0], 1'b0};
            end
            iter_d = iter_q + ITER_W'(1);
            if (iter_q == ITER_W'(DIV_ITERS - 1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q    <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            iter_q <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            d_q    <= d_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            iter_q <= iter_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign done_o = done_q;
    assign q_o    = sat_quot(quo_q);

endmodule

// File: rtl/freq_meter.sv
// Frequency meter: measures the period between hysteresis-qualified rising
// zero crossings and converts it to a 2^32/period frequency control word.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int                HYST    = 16,
    parameter logic [CTRL_W-1:0] TIMEOUT = 32'h0100_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [SAMPLE_W-1:0] sample_i,
    output logic [CTRL_W-1:0]          freq_ctrl_o,
    output logic                       freq_valid_o,
    output logic [CTRL_W-1:0]          period_o,
    output logic                       timeout_o,
    output logic                       busy_o
);

    localparam logic signed [SAMPLE_W-1:0] HYST_POS = SAMPLE_W'(HYST);
    localparam logic signed [SAMPLE_W-1:0] HYST_NEG = -HYST_POS;

    state_e            state_q, state_d;
    logic              armed_q, armed_d;
    logic              trig;
    logic [CTRL_W-1:0] count_q, count_d;
    logic              cnt_sat;
    logic [CTRL_W-1:0] period_q, period_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              timeout_q, timeout_d;
    logic              valid_q, valid_d;

    logic              div_start;
    logic              div_done;
    logic [CTRL_W-1:0] div_q;

    // Crossing detector: arm below -HYST, fire on the first sample at or above +HYST.
    always_comb begin
        armed_d = armed_q;
        trig    = 1'b0;
        if (sample_i <= HYST_NEG) begin
            armed_d = 1'b1;
        end else if (armed_q && (sample_i >= HYST_POS)) begin
            trig    = 1'b1;
            armed_d = 1'b0;
        end
    end

    assign cnt_sat = (count_q >= TIMEOUT);

    always_comb begin
        if (trig) begin
            count_d = CTRL_W'(1);
        end else if (cnt_sat) begin
            count_d = count_q;
        end else begin
            count_d = count_q + CTRL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT_FIRST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WAIT_FIRST: if (trig) state_d = MEASURE;
            MEASURE: begin
                if (trig) begin
                    state_d = DIVIDE;
                end else if (cnt_sat) begin
                    state_d = WAIT_FIRST;
                end
            end
            DIVIDE:     if (div_done) state_d = MEASURE;
            default:    state_d = WAIT_FIRST;
        endcase
    end

    // On a trigger edge count_q already equals the clocks elapsed since the
    // previous trigger, which is exactly the period to report.
    always_comb begin
        div_start = 1'b0;
        period_d  = period_q;
        ctrl_d    = ctrl_q;
        timeout_d = timeout_q;
        valid_d   = 1'b0;
        busy_o    = (state_q == DIVIDE);
        unique case (state_q)
            MEASURE: begin
                if (trig) begin
                    div_start = 1'b1;
                    period_d  = count_q;
                end else if (cnt_sat) begin
                    ctrl_d    = '0;
                    period_d  = '0;
                    timeout_d = 1'b1;
                    valid_d   = 1'b1;
                end
            end
            DIVIDE: begin
                if (div_done) begin
                    ctrl_d    = div_q;
                    timeout_d = 1'b0;
                    valid_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            armed_q   <= 1'b0;
            count_q   <= '0;
            period_q  <= '0;
            ctrl_q    <= '0;
            timeout_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            armed_q   <= armed_d;
            count_q   <= count_d;
            period_q  <= period_d;
            ctrl_q    <= ctrl_d;
            timeout_q <= timeout_d;
            valid_q   <= valid_d;
        end
    end

    freq_meter_recip_div u_recip_div (
        .clk     (clk),
        .rst     (rst),
        .start_i (div_start),
        .d_i     (count_q),
        .done_o  (div_done),
        .q_o     (div_q)
    );

    assign freq_ctrl_o  = ctrl_q;
    assign period_o     = period_q;
    assign timeout_o    = timeout_q;
    assign freq_valid_o = valid_q;

endmodule
